duc_tx_sequencer: RTL and testbench

Local-bus master that sequences one DUC transmission on lbs_clk. Per frame it issues down-start, loads baseband samples into the DUC sample RAM window, issues down-end and trigger, then polls the DUC command register until the DUC clears it. It shares the local-bus write port with the host: the host owns it while the sequencer is idle, and the sequencer owns it while busy. It also supports repeat transmission of the already-loaded frame without reloading.

---
 rtl/duc_tx_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_duc_tx_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duc_tx_sequencer.sv
// duc_tx_sequencer: local-bus master that sequences DUC transmissions on lbs_clk.
// Per frame: down-start command, sample load into the RAM window, down-end,
// trigger, then poll the DUC command register until it is cleared. It can
// re-trigger the already-loaded frame without reloading it.
// The host owns the write port while idle; the sequencer owns it while busy.
// Optional feature: define DUC_SEQ_ABORT_EN to make the abort input effective.
module duc_tx_sequencer #(
   parameter logic [13:0] START_ADDR  = 14'd12000,
   parameter int unsigned MAX_LEN     = 3840,
   parameter logic [13:0] CMD_ADDR    = 14'd16000,
   parameter int unsigned CMD_GAP     = 4,
   parameter logic [23:0] TIMEOUT_CYC = 24'd8000000
) (
   input  logic        rst_n,
   input  logic        lbs_clk,
   input  logic        start,
   input  logic [11:0] frame_len,
   input  logic [7:0]  repeat_n,
   input  logic        abort,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   output logic        s_ready,
   input  logic        host_we,
   input  logic [13:0] host_addr,
   input  logic [31:0] host_din,
   output logic        m_we,
   output logic [13:0] m_addr,
   output logic [31:0] m_din,
   input  logic [31:0] duc_cmd_register,
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic        err_cfg,
   output logic        host_drop,
   output logic [7:0]  frames_sent
);

   localparam logic [31:0] CMD_DOWN_START = 32'h0000_5555;
   localparam logic [31:0] CMD_DOWN_END   = 32'h0000_8888;
   localparam logic [31:0] CMD_TRIGGER    = 32'h0000_FFFF;
   localparam logic [12:0] MAX_LEN_W      = 13'(MAX_LEN);
   localparam logic [7:0]  GAP_LAST       = 8'(CMD_GAP - 1);
   localparam logic [23:0] TO_LAST        = TIMEOUT_CYC - 24'd1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CMD_START,
      S_LOAD,
      S_CMD_END,
      S_CMD_TRIG,
      S_GAP,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_FIN
   } state_t;

   state_t      state, state_nx;
   state_t      gap_ret, gap_ret_nx;
   logic [7:0]  gap_cnt, gap_cnt_nx;
   logic [11:0] len, len_nx;
   logic [11:0] idx, idx_nx;
   logic [7:0]  rpt, rpt_nx;
   logic        first, first_nx;
   logic [23:0] to_cnt, to_cnt_nx;
   logic        m_we_nx;
   logic [13:0] m_addr_nx;
   logic [31:0] m_din_nx;
   logic        done_nx;
   logic        err_timeout_nx, err_cfg_nx, host_drop_nx;
   logic [7:0]  frames_nx;
   logic        to_hit;

   assign busy    = (state != S_IDLE);
   assign s_ready = (state == S_LOAD) && (idx != len);
   assign to_hit  = (to_cnt == TO_LAST);

`ifdef DUC_SEQ_ABORT_EN
   logic finishing;
   logic abort_go;
   // Once the closing down-end write is under way, a further abort has nothing to add.
   assign finishing = (state == S_FIN) || ((state == S_GAP) && (gap_ret == S_IDLE));
   assign abort_go  = abort && busy && !finishing;
`else
   logic unused_abort;
   assign unused_abort = abort;
`endif

   // State, bus and status registers; reset clears everything and returns to IDLE.
   always_ff @(posedge lbs_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         gap_ret     <= S_IDLE;
         gap_cnt     <= '0;
         len         <= '0;
         idx         <= '0;
         rpt         <= '0;
         first       <= 1'b0;
         to_cnt      <= '0;
         m_we        <= 1'b0;
         m_addr      <= '0;
         m_din       <= '0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         err_cfg     <= 1'b0;
         host_drop   <= 1'b0;
         frames_sent <= '0;
      end else begin
         state       <= state_nx;
         gap_ret     <= gap_ret_nx;
         gap_cnt     <= gap_cnt_nx;
         len         <= len_nx;
         idx         <= idx_nx;
         rpt         <= rpt_nx;
         first       <= first_nx;
         to_cnt      <= to_cnt_nx;
         m_we        <= m_we_nx;
         m_addr      <= m_addr_nx;
         m_din       <= m_din_nx;
         done        <= done_nx;
         err_timeout <= err_timeout_nx;
         err_cfg     <= err_cfg_nx;
         host_drop   <= host_drop_nx;
         frames_sent <= frames_nx;
      end
   end

   // Next-state, bus write and status decode.
   always_comb begin
      state_nx       = state;
      gap_ret_nx     = gap_ret;
      gap_cnt_nx     = gap_cnt;
      len_nx         = len;
      idx_nx         = idx;
      rpt_nx         = rpt;
      first_nx       = first;
      to_cnt_nx      = to_cnt;
      m_we_nx        = 1'b0;
      m_addr_nx      = m_addr;
      m_din_nx       = m_din;
      done_nx        = 1'b0;
      err_timeout_nx = err_timeout;
      err_cfg_nx     = err_cfg;
      host_drop_nx   = host_drop;
      frames_nx      = frames_sent;

      if (busy && host_we) begin
         host_drop_nx = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (host_we) begin
               m_we_nx   = 1'b1;
               m_addr_nx = host_addr;
               m_din_nx  = host_din;
            end
            if (start) begin
               if ((frame_len == '0) || ({1'b0, frame_len} > MAX_LEN_W)) begin
                  err_cfg_nx = 1'b1;
               end else begin
                  err_timeout_nx = 1'b0;
                  err_cfg_nx     = 1'b0;
                  host_drop_nx   = 1'b0;
                  frames_nx      = '0;
                  len_nx         = frame_len;
                  rpt_nx         = repeat_n;
                  first_nx       = 1'b1;
                  idx_nx         = '0;
                  state_nx       = S_CMD_START;
               end
            end
         end
         S_CMD_START: begin
            m_we_nx    = 1'b1;
            m_addr_nx  = CMD_ADDR;
            m_din_nx   = CMD_DOWN_START;
            gap_cnt_nx = '0;
            gap_ret_nx = first ? S_LOAD : S_CMD_END;
            state_nx   = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nx = gap_ret;
               if (gap_ret == S_WAIT_ACK) begin
                  to_cnt_nx = '0;
               end
               if (gap_ret == S_LOAD) begin
                  idx_nx   = '0;
                  first_nx = 1'b0;
               end
            end else begin
               gap_cnt_nx = gap_cnt + 8'd1;
            end
         end
         S_LOAD: begin
            if (s_valid && s_ready) begin
               m_we_nx   = 1'b1;
               m_addr_nx = START_ADDR + {2'b00, idx};
               m_din_nx  = s_data;
               idx_nx    = idx + 12'd1;
               if ((idx + 12'd1) == len) begin
                  state_nx = S_CMD_END;
               end
            end
         end
         S_CMD_END: begin
            m_we_nx    = 1'b1;
            m_addr_nx  = CMD_ADDR;
            m_din_nx   = CMD_DOWN_END;
            gap_cnt_nx = '0;
            gap_ret_nx = S_CMD_TRIG;
            state_nx   = S_GAP;
         end
         S_CMD_TRIG: begin
            m_we_nx    = 1'b1;
            m_addr_nx  = CMD_ADDR;
            m_din_nx   = CMD_TRIGGER;
            gap_cnt_nx = '0;
            gap_ret_nx = S_WAIT_ACK;
            state_nx   = S_GAP;
         end
         S_WAIT_ACK: begin
            to_cnt_nx = to_cnt + 24'd1;
            if (duc_cmd_register == CMD_TRIGGER) begin
               state_nx = S_WAIT_DONE;
            end else if (to_hit) begin
               err_timeout_nx = 1'b1;
               state_nx       = S_FIN;
            end
         end
         S_WAIT_DONE: begin
            to_cnt_nx = to_cnt + 24'd1;
            if (duc_cmd_register == '0) begin
               if (frames_sent != 8'hFF) begin
                  frames_nx = frames_sent + 8'd1;
               end
               if (rpt != '0) begin
                  rpt_nx   = rpt - 8'd1;
                  state_nx = S_CMD_START;
               end else begin
                  done_nx  = 1'b1;
                  state_nx = S_IDLE;
               end
            end else if (to_hit) begin
               err_timeout_nx = 1'b1;
               state_nx       = S_FIN;
            end
         end
         S_FIN: begin
            m_we_nx    = 1'b1;
            m_addr_nx  = CMD_ADDR;
            m_din_nx   = CMD_DOWN_END;
            gap_cnt_nx = '0;
            gap_ret_nx = S_IDLE;
            state_nx   = S_GAP;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

`ifdef DUC_SEQ_ABORT_EN
      // Abort wins over any write decoded this cycle; the closing down-end follows next cycle.
      if (abort_go) begin
         m_we_nx  = 1'b0;
         done_nx  = 1'b0;
         state_nx = S_FIN;
      end
`endif
   end

endmodule

// File: tb/tb_duc_tx_sequencer.sv
// tb_duc_tx_sequencer: scoreboard bench for duc_tx_sequencer.
// Expected bus writes are queued by the stimulus; a negedge monitor pops and
// compares every m_we beat. A small DUC model acknowledges and clears triggers.
module tb_duc_tx_sequencer;

   localparam logic [13:0] CMD = 14'd16000;
   localparam logic [13:0] SA  = 14'd12000;

   typedef struct {
      logic [13:0] a;
      logic [31:0] d;
   } wr_t;

   logic        rst_n = 1'b0;
   logic        lbs_clk = 1'b0;
   logic        start = 1'b0;
   logic [11:0] frame_len = '0;
   logic [7:0]  repeat_n = '0;
   logic        abort = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic        host_we = 1'b0;
   logic [13:0] host_addr = '0;
   logic [31:0] host_din = '0;
   logic        m_we;
   logic [13:0] m_addr;
   logic [31:0] m_din;
   logic [31:0] duc_cmd_register = '0;
   logic        busy, done, err_timeout, err_cfg, host_drop;
   logic [7:0]  frames_sent;

   int   checks = 0;
   int   failures = 0;
   wr_t  exp_q[$];
   int   cyc = 0;
   int   done_cnt = 0;
   int   last_ffff = 0;
   int   last_8888 = 0;
   bit   never_clear = 1'b0;

   duc_tx_sequencer #(.TIMEOUT_CYC(24'd1000)) dut (
      .rst_n(rst_n), .lbs_clk(lbs_clk), .start(start), .frame_len(frame_len),
      .repeat_n(repeat_n), .abort(abort), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
      .m_we(m_we), .m_addr(m_addr), .m_din(m_din), .duc_cmd_register(duc_cmd_register),
      .busy(busy), .done(done), .err_timeout(err_timeout), .err_cfg(err_cfg),
      .host_drop(host_drop), .frames_sent(frames_sent)
   );

   always #5 lbs_clk = ~lbs_clk;

   function automatic logic [31:0] pat(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {v + 16'h1000, ~v};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [13:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic push_frame(input int n, input int reps);
      push(CMD, 32'h5555);
      for (int i = 0; i < n; i++) push(SA + 14'(i), pat(i));
      push(CMD, 32'h8888);
      push(CMD, 32'hFFFF);
      for (int r = 0; r < reps; r++) begin
         push(CMD, 32'h5555);
         push(CMD, 32'h8888);
         push(CMD, 32'hFFFF);
      end
   endtask

   task automatic do_start(input logic [11:0] len, input logic [7:0] rep);
      start = 1'b1;
      frame_len = len;
      repeat_n = rep;
      @(posedge lbs_clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int n, input bit stall);
      int  i;
      int  guard;
      bit  hs;
      i = 0;
      guard = 0;
      s_data = pat(0);
      s_valid = 1'b1;
      while (i < n && guard < 20000) begin
         @(negedge lbs_clk);
         hs = s_valid && s_ready;
         @(posedge lbs_clk); #1;
         if (hs) i++;
         guard++;
         s_data = pat(i);
         s_valid = (i < n) && (!stall || (guard % 5 != 2));
      end
      s_valid = 1'b0;
      check("feed_count", i, n);
   endtask

   task automatic wait_idle(input int maxc, input string nm);
      int n;
      n = 0;
      while (busy && n < maxc) begin
         @(posedge lbs_clk); #1;
         n++;
      end
      check(nm, busy, 1'b0);
   endtask

   // DUC model: acknowledge a trigger, then clear it 50 cycles later unless told not to.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge lbs_clk);
         if (m_we && m_addr == CMD && m_din == 32'hFFFF) begin
            duc_cmd_register <= 32'hFFFF;
            cnt = 50;
         end else if (duc_cmd_register == 32'hFFFF && !never_clear) begin
            if (cnt > 1) cnt--;
            else duc_cmd_register <= '0;
         end
      end
   end

   // Monitor: scoreboard pop on every bus write, command spacing, done pulse width.
   initial begin
      wr_t e;
      bit  cmd_pend;
      int  last_cmd;
      bit  prev_done;
      cmd_pend = 1'b0;
      last_cmd = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge lbs_clk);
         cyc++;
         if (done) begin
            done_cnt++;
            checks++;
            if (prev_done) begin
               failures++;
               $display("FAIL done_width: done high %0d cycles in a row, required 1", 2);
            end
         end
         prev_done = done;
         if (m_we) begin
            if (cmd_pend) begin
               checks++;
               if (cyc - last_cmd < 5) begin
                  failures++;
                  $display("FAIL cmd_gap: %0d idle cycles after command, required >=4", cyc - last_cmd - 1);
               end
               cmd_pend = 1'b0;
            end
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL bus_write: unexpected %0h@%0d, required none", m_din, m_addr);
            end else begin
               e = exp_q.pop_front();
               if (m_addr !== e.a || m_din !== e.d) begin
                  failures++;
                  $display("FAIL bus_write: got %0h@%0d expected %0h@%0d", m_din, m_addr, e.d, e.a);
               end
            end
            if (m_addr == CMD) begin
               cmd_pend = 1'b1;
               last_cmd = cyc;
               if (m_din == 32'hFFFF) last_ffff = cyc;
               if (m_din == 32'h8888) last_8888 = cyc;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      repeat (3) @(posedge lbs_clk);
      #1;
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_din", m_din, 0);
      check("rst_busy", busy, 0);
      check("rst_flags", {done, err_timeout, err_cfg, host_drop, s_ready}, 0);
      check("rst_frames", frames_sent, 0);
      rst_n = 1'b1;
      @(posedge lbs_clk); #1;

      // Host pass-through in IDLE: one cycle of latency, single-cycle strobe.
      push(14'd100, 32'h1234);
      host_we = 1'b1; host_addr = 14'd100; host_din = 32'h1234;
      @(posedge lbs_clk); #1;
      host_we = 1'b0;
      check("host_lat_we", m_we, 1);
      @(posedge lbs_clk); #1;
      check("host_pulse_end", m_we, 0);

      // Bad lengths: flag only, no bus activity.
      do_start(12'd0, 8'd0);
      repeat (3) @(posedge lbs_clk); #1;
      check("cfg0_err", err_cfg, 1);
      check("cfg0_busy", busy, 0);
      do_start(12'd3841, 8'd0);
      repeat (3) @(posedge lbs_clk); #1;
      check("cfg3841_err", err_cfg, 1);
      check("cfg3841_busy", busy, 0);

      // Four-sample frame with a host write dropped during LOAD.
      d0 = done_cnt;
      push_frame(4, 0);
      do_start(12'd4, 8'd0);
      check("cfg_cleared", err_cfg, 0);
      check("busy_run", busy, 1);
      repeat (6) @(posedge lbs_clk); #1;
      host_we = 1'b1; host_addr = 14'd200; host_din = 32'hDEAD;
      @(posedge lbs_clk); #1;
      host_we = 1'b0;
      feed(4, 1'b1);
      wait_idle(500, "f4_idle");
      repeat (2) @(posedge lbs_clk); #1;
      check("f4_done", done_cnt, d0 + 1);
      check("f4_frames", frames_sent, 1);
      check("f4_host_drop", host_drop, 1);
      check("f4_sb_empty", exp_q.size(), 0);

      // Full window, two repeats.
      d0 = done_cnt;
      push_frame(3840, 2);
      do_start(12'd3840, 8'd2);
      check("drop_cleared", host_drop, 0);
      feed(3840, 1'b1);
      wait_idle(1000, "full_idle");
      repeat (2) @(posedge lbs_clk); #1;
      check("full_done", done_cnt, d0 + 1);
      check("full_frames", frames_sent, 3);
      check("full_sb_empty", exp_q.size(), 0);

      // DUC never clears: timeout after 1000 wait cycles, closing down-end.
      d0 = done_cnt;
      never_clear = 1'b1;
      push_frame(2, 0);
      push(CMD, 32'h8888);
      do_start(12'd2, 8'd0);
      feed(2, 1'b1);
      wait_idle(3000, "to_idle");
      repeat (2) @(posedge lbs_clk); #1;
      check("to_err", err_timeout, 1);
      check("to_no_done", done_cnt, d0);
      check("to_frames", frames_sent, 0);
      check("to_gap", last_8888 - last_ffff, 1005);
      check("to_sb_empty", exp_q.size(), 0);
      never_clear = 1'b0;
      repeat (60) @(posedge lbs_clk); #1;

`ifdef DUC_SEQ_ABORT_EN
      // Abort mid-LOAD: down-end written, back to IDLE, no done.
      d0 = done_cnt;
      push(CMD, 32'h5555);
      for (int i = 0; i < 3; i++) push(SA + 14'(i), pat(i));
      push(CMD, 32'h8888);
      do_start(12'd8, 8'd0);
      feed(3, 1'b0);
      abort = 1'b1;
      @(posedge lbs_clk); #1;
      abort = 1'b0;
      check("ab_ready", s_ready, 0);
      wait_idle(100, "ab_idle");
      repeat (2) @(posedge lbs_clk); #1;
      check("ab_no_done", done_cnt, d0);
      check("ab_frames", frames_sent, 0);
      check("ab_sb_empty", exp_q.size(), 0);
`endif

      repeat (10) @(posedge lbs_clk); #1;
      check("final_sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
